// File: rtl/universal_register.sv
// rtl/universal_register.sv - parametrised load/inc/dec/shift register with carry capture and zero flag
//
// Purpose:
//   General-purpose datapath register (address, program counter, accumulator).
//   One command acts per cycle, chosen by fixed priority:
//   clr > load > inc > dec > shl > shr > hold.
//
// Parameters:
//   WIDTH     - register width in bits (>= 2)
//   IN_WIDTH  - width of the parallel load bus (>= WIDTH); upper bits are discarded
//   SATURATE  - 0: inc/dec wrap modulo 2^WIDTH; 1: inc/dec clamp at all-ones/zero
//   RESET_VAL - register value while and after reset
//
// Ports:
//   i_clk     - clock, state changes on rising edge
//   i_rst_n   - asynchronous active-low reset
//   i_clr     - clear register and carry to zero
//   i_load    - load i_indata[WIDTH-1:0]
//   i_inc     - increment by one
//   i_dec     - decrement by one
//   i_shl     - shift left, i_sin enters the LSB
//   i_shr     - logical shift right, i_sin enters the MSB
//   i_sin     - serial input bit for shifts
//   i_indata  - parallel load data
//   o_outdata - register contents
//   o_cout    - registered carry/borrow/shift-out of the last operation
//   o_zero    - high when o_outdata is zero
module universal_register #(
  parameter int                 WIDTH     = 12,
  parameter int                 IN_WIDTH  = 16,
  parameter int                 SATURATE  = 0,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_clr,
  input  logic                i_load,
  input  logic                i_inc,
  input  logic                i_dec,
  input  logic                i_shl,
  input  logic                i_shr,
  input  logic                i_sin,
  input  logic [IN_WIDTH-1:0] i_indata,
  output logic [WIDTH-1:0]    o_outdata,
  output logic                o_cout,
  output logic                o_zero
);

  localparam logic [WIDTH-1:0] LP_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_data;
  logic             r_cout;
  logic [WIDTH-1:0] w_next_data;
  logic             w_next_cout;
  logic             w_all_ones;
  logic             w_is_zero;
  logic             w_unused_indata;

  assign w_all_ones = &r_data;
  assign w_is_zero  = ~|r_data;

  // Upper load bits are intentionally dropped; the reduction keeps every bit referenced.
  assign w_unused_indata = ^i_indata;

  always_comb begin
    w_next_data = r_data;
    w_next_cout = r_cout;
    if (i_clr) begin
      w_next_data = '0;
      w_next_cout = 1'b0;
    end else if (i_load) begin
      w_next_data = i_indata[WIDTH-1:0];
      w_next_cout = 1'b0;
    end else if (i_inc) begin
      // Carry flags the all-ones boundary in both modes; saturating mode also holds there.
      w_next_cout = w_all_ones;
      if (!(SATURATE != 0 && w_all_ones)) begin
        w_next_data = r_data + LP_ONE;
      end
    end else if (i_dec) begin
      // Borrow flags the zero boundary in both modes; saturating mode also holds there.
      w_next_cout = w_is_zero;
      if (!(SATURATE != 0 && w_is_zero)) begin
        w_next_data = r_data - LP_ONE;
      end
    end else if (i_shl) begin
      w_next_data = {r_data[WIDTH-2:0], i_sin};
      w_next_cout = r_data[WIDTH-1];
    end else if (i_shr) begin
      w_next_data = {i_sin, r_data[WIDTH-1:1]};
      w_next_cout = r_data[0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data <= RESET_VAL;
      r_cout <= 1'b0;
    end else begin
      r_data <= w_next_data;
      r_cout <= w_next_cout;
    end
  end

  assign o_outdata = r_data;
  assign o_cout    = r_cout;
  assign o_zero    = w_is_zero;

endmodule

// File: tb/tb_universal_register.sv
// tb/tb_universal_register.sv - directed and randomized check of universal_register (wrap and saturate)
module tb_universal_register;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr, load, inc, dec, shl, shr, sin;
  logic [15:0] indata;
  logic [11:0] out_w, out_s;
  logic        cout_w, cout_s, zero_w, zero_s;

  int checks = 0;
  int errors = 0;

  // Reference state: value and carry for the wrapping and saturating instances
  int m_w, m_s;
  bit mc_w, mc_s;

  always #5 clk = ~clk;

  universal_register #(
    .WIDTH(12), .IN_WIDTH(16), .SATURATE(0), .RESET_VAL(12'h5A5)
  ) u_dut_wrap (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_load(load), .i_inc(inc),
    .i_dec(dec), .i_shl(shl), .i_shr(shr), .i_sin(sin), .i_indata(indata),
    .o_outdata(out_w), .o_cout(cout_w), .o_zero(zero_w)
  );

  universal_register #(
    .WIDTH(12), .IN_WIDTH(16), .SATURATE(1), .RESET_VAL(12'h000)
  ) u_dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_load(load), .i_inc(inc),
    .i_dec(dec), .i_shl(shl), .i_shr(shr), .i_sin(sin), .i_indata(indata),
    .o_outdata(out_s), .o_cout(cout_s), .o_zero(zero_s)
  );

  // Next {carry, value} from the command rules, using integer arithmetic on 0..4095.
  function automatic logic [12:0] ref_next(input int v, input bit c, input bit sat,
                                           input bit cl, ld, ic, dc, sl, sr, s,
                                           input int data);
    int nv;
    bit nc;
    nv = v;
    nc = c;
    if (cl) begin
      nv = 0; nc = 0;
    end else if (ld) begin
      nv = data % 4096; nc = 0;
    end else if (ic) begin
      if (v == 4095) begin nv = sat ? 4095 : 0; nc = 1; end
      else begin nv = v + 1; nc = 0; end
    end else if (dc) begin
      if (v == 0) begin nv = sat ? 0 : 4095; nc = 1; end
      else begin nv = v - 1; nc = 0; end
    end else if (sl) begin
      nc = (v / 2048) == 1;
      nv = (v * 2 + int'(s)) % 4096;
    end else if (sr) begin
      nc = (v % 2) == 1;
      nv = v / 2 + int'(s) * 2048;
    end
    return {nc, 12'(nv)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".wrap.out"},  32'(out_w),  32'(m_w));
    chk({tag, ".wrap.cout"}, 32'(cout_w), 32'(mc_w));
    chk({tag, ".wrap.zero"}, 32'(zero_w), 32'(m_w == 0));
    chk({tag, ".sat.out"},   32'(out_s),  32'(m_s));
    chk({tag, ".sat.cout"},  32'(cout_s), 32'(mc_s));
    chk({tag, ".sat.zero"},  32'(zero_s), 32'(m_s == 0));
  endtask

  // Drive one command set, clock it in, advance the model, check #1 after the edge.
  task automatic step(input string tag, input bit cl, ld, ic, dc, sl, sr, s,
                      input logic [15:0] data);
    logic [12:0] r;
    clr = cl; load = ld; inc = ic; dec = dc; shl = sl; shr = sr; sin = s; indata = data;
    @(posedge clk);
    r = ref_next(m_w, mc_w, 1'b0, cl, ld, ic, dc, sl, sr, s, int'(data));
    mc_w = r[12]; m_w = int'(r[11:0]);
    r = ref_next(m_s, mc_s, 1'b1, cl, ld, ic, dc, sl, sr, s, int'(data));
    mc_s = r[12]; m_s = int'(r[11:0]);
    #1;
    check_all(tag);
  endtask

  // Pulse reset low between edges; outputs must follow immediately without a clock edge.
  task automatic reset_pulse(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_w = 'h5A5; mc_w = 0; m_s = 0; mc_s = 0;
    check_all(tag);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int n_cout;
    rst_n = 1'b1;
    {clr, load, dec, shl, shr, sin} = '0;
    inc = 1'b1;
    indata = '0;
    m_w = 'h5A5; mc_w = 0; m_s = 0; mc_s = 0;

    // Reset asserted asynchronously, held across an edge with inc active
    #2 rst_n = 1'b0;
    #1;
    check_all("reset_async");
    chk("reset_val", 32'(out_w), 32'h5A5);
    @(posedge clk);
    #1;
    check_all("reset_hold_edge");
    @(negedge clk);
    rst_n = 1'b1;
    step("inc_after_reset", 0, 0, 1, 0, 0, 0, 0, 16'h0);
    chk("inc_after_reset.const", 32'(out_w), 32'h5A6);

    // Reset mid-sequence aborts the increments
    step("inc_seq", 0, 0, 1, 0, 0, 0, 0, 16'h0);
    reset_pulse("reset_mid");
    step("inc_resume", 0, 0, 1, 0, 0, 0, 0, 16'h0);
    chk("inc_resume.const", 32'(out_w), 32'h5A6);

    // Load truncation and clr priority
    step("load_trunc", 0, 1, 0, 0, 0, 0, 0, 16'hF123);
    chk("load_trunc.const", 32'(out_w), 32'h123);
    chk("load_trunc.zero", 32'(zero_w), 32'h0);
    step("clr_over_load", 1, 1, 0, 0, 0, 0, 0, 16'hF123);
    chk("clr_over_load.const", 32'(out_w), 32'h0);
    chk("clr_over_load.zero", 32'(zero_w), 32'h1);

    // Wrap through all-ones and back
    step("load_ffe", 0, 1, 0, 0, 0, 0, 0, 16'h0FFE);
    step("inc1", 0, 0, 1, 0, 0, 0, 0, 16'h0);
    chk("inc1.const", 32'(out_w), 32'hFFF);
    step("inc2", 0, 0, 1, 0, 0, 0, 0, 16'h0);
    chk("inc2.const", 32'({cout_w, zero_w, out_w}), 32'h3000);
    step("inc3", 0, 0, 1, 0, 0, 0, 0, 16'h0);
    chk("inc3.const", 32'({cout_w, out_w}), 32'h001);
    step("dec1", 0, 0, 0, 1, 0, 0, 0, 16'h0);
    chk("dec1.const", 32'(out_w), 32'h000);
    step("dec2", 0, 0, 0, 1, 0, 0, 0, 16'h0);
    chk("dec2.const", 32'({cout_w, out_w}), 32'h1FFF);

    // Saturating instance clamps at both ends
    step("sat_load_fff", 0, 1, 0, 0, 0, 0, 0, 16'h0FFF);
    step("sat_inc", 0, 0, 1, 0, 0, 0, 0, 16'h0);
    chk("sat_inc.const", 32'({cout_s, out_s}), 32'h1FFF);
    step("sat_load_0", 0, 1, 0, 0, 0, 0, 0, 16'h0000);
    step("sat_dec", 0, 0, 0, 1, 0, 0, 0, 16'h0);
    chk("sat_dec.const", 32'({cout_s, out_s}), 32'h1000);

    // Shifts with serial input
    step("load_801", 0, 1, 0, 0, 0, 0, 0, 16'h0801);
    step("shl0", 0, 0, 0, 0, 1, 0, 0, 16'h0);
    chk("shl0.const", 32'({cout_w, out_w}), 32'h1002);
    step("shr1", 0, 0, 0, 0, 0, 1, 1, 16'h0);
    chk("shr1.const", 32'({cout_w, out_w}), 32'h0801);
    step("shr0", 0, 0, 0, 0, 0, 1, 0, 16'h0);
    chk("shr0.const", 32'({cout_w, out_w}), 32'h1400);

    // Priority collisions
    step("inc_dec", 0, 0, 1, 1, 0, 0, 0, 16'h0);
    step("shl_shr", 0, 0, 0, 0, 1, 1, 1, 16'h0);
    step("hold", 0, 0, 0, 0, 0, 0, 1, 16'hABCD);

    // Full cycle of increments returns to start with exactly one carry pulse
    step("load_0", 0, 1, 0, 0, 0, 0, 0, 16'h0);
    n_cout = 0;
    for (int i = 0; i < 4096; i++) begin
      step("full_inc", 0, 0, 1, 0, 0, 0, 0, 16'h0);
      if (cout_w) n_cout++;
    end
    chk("full_inc.pulses", 32'(n_cout), 32'd1);
    chk("full_inc.final", 32'(out_w), 32'h0);

    // Randomized commands against the reference model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        reset_pulse("rand_reset");
      end else begin
        step("rand",
             $urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 2) == 0,  $urandom_range(0, 2) == 0,
             $urandom_range(0, 2) == 0,  $urandom_range(0, 2) == 0,
             1'($urandom), 16'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/universal_register.md
# universal_register

Parametrised general-purpose register for the basic computer datapath, generalising the fixed 12-bit load/increment/clear register. It adds decrement, logical shifts with serial input, carry/borrow/shift-out capture, an optional saturating mode and a zero flag. It is used for address, program-counter and accumulator-style registers of any width.

## Interface
- WIDTH, 12, register width in bits (≥2)
- IN_WIDTH, 16, width of indata bus (≥ WIDTH); only indata[WIDTH-1:0] is loaded
- SATURATE, 0, 0 = inc/dec wrap modulo 2^WIDTH; 1 = inc/dec clamp at all-ones/zero
- RESET_VAL, 0, value of outdata after reset (truncated to WIDTH)

- clk  in  1  clock, all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  clear register to zero
- load  in  1  load indata[WIDTH-1:0]
- inc  in  1  increment by 1
- dec  in  1  decrement by 1
- shl  in  1  shift left, sin enters LSB
- shr  in  1  shift right logical, sin enters MSB
- sin  in  1  serial input bit for shifts
- indata  in  IN_WIDTH  parallel load data
- outdata  out  WIDTH  register contents
- cout  out  1  registered carry/borrow/shift-out of the last operation
- zero  out  1  1 when outdata == 0 (combinational from register)

## Operation
- Fixed priority per cycle: clr > load > inc > dec > shl > shr > hold. Only the highest asserted command acts; the rest are ignored that cycle.
- clr: outdata ← 0, cout ← 0.
- load: outdata ← indata[WIDTH-1:0]; upper IN_WIDTH-WIDTH bits discarded; cout ← 0.
- inc, SATURATE=0: outdata ← outdata+1 mod 2^WIDTH; cout ← 1 only when old value is all-ones (wrap to 0), else 0.
- inc, SATURATE=1: all-ones holds, cout ← 1; otherwise +1, cout ← 0.
- dec, SATURATE=0: outdata ← outdata−1 mod 2^WIDTH; cout ← 1 (borrow) only when old value is 0 (wrap to all-ones).
- dec, SATURATE=1: 0 holds, cout ← 1; otherwise −1, cout ← 0.
- shl: outdata ← {outdata[WIDTH-2:0], sin}; cout ← old outdata[WIDTH-1].
- shr: outdata ← {sin, outdata[WIDTH-1:1]}; cout ← old outdata[0].
- hold (no command): outdata and cout unchanged.
- zero tracks the register every cycle, including during and right after reset (zero = (RESET_VAL==0)).

## Timing
- Single-cycle latency: command sampled at rising edge N; outdata/cout show the result after edge N. zero follows outdata combinationally.
- Commands may change every cycle; back-to-back inc for 2^WIDTH cycles returns to the start value with exactly one cout pulse (SATURATE=0).
- Reset: rst_n low forces outdata = RESET_VAL, cout = 0 immediately, independent of clk. Commands are ignored while rst_n is low. Reset asserted mid-sequence aborts that sequence. First update occurs on the first rising edge after rst_n is high. rst_n release is synchronised upstream.
- No handshake. The block is always ready. Inputs must be stable around the rising edge.

## Test plan
- Reset: RESET_VAL=12'h5A5, drive inc=1, pulse rst_n low between edges -> outdata=12'h5A5, cout=0 immediately. Increments resume from 12'h5A6 on the first edge after release.
- Load/truncate: load=1, indata=16'hF123 -> outdata=12'h123, cout=0, zero=0. Then clr=1 with load=1 -> outdata=0, zero=1 (clr priority).
- Wrap: load 12'hFFE, then inc for 3 cycles -> 12'hFFF, 12'h000 (cout=1, zero=1), 12'h001 (cout=0). Then dec twice -> 12'h000, then 12'hFFF with cout=1.
- Saturate (SATURATE=1): load 12'hFFF, inc -> stays 12'hFFF, cout=1. Load 0, dec -> stays 0, cout=1.
- Shifts: load 12'h801, shl with sin=0 -> 12'h002, cout=1. shr with sin=1 -> 12'h801, cout=0. shr with sin=0 -> 12'h400, cout=1.
- Random: 1500 cycles of random commands and data, checked against a reference model, including priority collisions (inc&dec -> inc, shl&shr -> shl) -> zero mismatches.
